// File: rtl/ahb_arbiter.sv
// Two-master AHB bus arbiter: M1 (data) has priority over M0 (instruction),
// with a tenure limit for unlocked owners and a data-phase mux one beat behind.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_TENURE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       HReq_M0,
    input  logic                       HReq_M1,
    input  logic                       HLock_M0,
    input  logic                       HLock_M1,
    input  logic [ADDR_W-1:0]          HAddress_M0,
    input  logic [ADDR_W-1:0]          HAddress_M1,
    input  logic [`AHB_TRANS_BITS-1:0] HTrans_M0,
    input  logic [`AHB_TRANS_BITS-1:0] HTrans_M1,
    input  logic [`AHB_SIZE_BITS-1:0]  HSize_M0,
    input  logic [`AHB_SIZE_BITS-1:0]  HSize_M1,
    input  logic                       HWrite_M0,
    input  logic                       HWrite_M1,
    input  logic [DATA_W-1:0]          HWrite_data_M0,
    input  logic [DATA_W-1:0]          HWrite_data_M1,
    input  logic                       HReady,
    output logic                       HGrant_M0,
    output logic                       HGrant_M1,
    output logic [1:0]                 HMaster,
    output logic                       HMastLock,
    output logic [ADDR_W-1:0]          HAddress,
    output logic [`AHB_TRANS_BITS-1:0] HTrans,
    output logic [`AHB_SIZE_BITS-1:0]  HSize,
    output logic                       HWrite,
    output logic [DATA_W-1:0]          HWrite_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } own_t;

    localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE - 1);

    own_t       owner;
    own_t       data_owner;
    own_t       owner_nxt;
    logic [7:0] tenure_cnt;
    logic [7:0] tenure_nxt;
    logic       own_req;
    logic       own_lock;
    logic       oth_req;

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;
        case (owner)
            OWN_M0: begin
                own_req  = HReq_M0;
                own_lock = HLock_M0;
                oth_req  = HReq_M1;
            end
            OWN_M1: begin
                own_req  = HReq_M1;
                own_lock = HLock_M1;
                oth_req  = HReq_M0;
            end
            default: ;
        endcase

        owner_nxt = OWN_NONE;
        if (own_req && own_lock) begin
            owner_nxt = owner;
        end else if (own_req && (!oth_req || tenure_cnt < TENURE_MAX)) begin
            owner_nxt = owner;
        end else if (own_req) begin
            // Tenure expired with the other master waiting: hand over regardless of priority.
            owner_nxt = (owner == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (HReq_M1) begin
            owner_nxt = OWN_M1;
        end else if (HReq_M0) begin
            owner_nxt = OWN_M0;
        end

        tenure_nxt = 8'd0;
        if (owner_nxt == owner && owner != OWN_NONE) begin
            tenure_nxt = (tenure_cnt < TENURE_MAX) ? tenure_cnt + 8'd1 : tenure_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_NONE;
            data_owner <= OWN_NONE;
            tenure_cnt <= 8'd0;
            HGrant_M0  <= 1'b0;
            HGrant_M1  <= 1'b0;
        end else if (HReady) begin
            owner      <= owner_nxt;
            data_owner <= owner;
            tenure_cnt <= tenure_nxt;
            HGrant_M0  <= (owner_nxt == OWN_M0);
            HGrant_M1  <= (owner_nxt == OWN_M1);
        end
    end

    assign HMaster = owner;

    // Address phase follows owner; data phase follows data_owner, one beat later.
    always_comb begin
        HAddress    = '0;
        HTrans      = '0;
        HSize       = `AHB_SIZE_BITS'(2);
        HWrite      = 1'b0;
        HMastLock   = 1'b0;
        case (owner)
            OWN_M0: begin
                HAddress  = HAddress_M0;
                HTrans    = HTrans_M0;
                HSize     = HSize_M0;
                HWrite    = HWrite_M0;
                HMastLock = HLock_M0;
            end
            OWN_M1: begin
                HAddress  = HAddress_M1;
                HTrans    = HTrans_M1;
                HSize     = HSize_M1;
                HWrite    = HWrite_M1;
                HMastLock = HLock_M1;
            end
            default: ;
        endcase

        HWrite_data = '0;
        case (data_owner)
            OWN_M0:  HWrite_data = HWrite_data_M0;
            OWN_M1:  HWrite_data = HWrite_data_M1;
            default: ;
        endcase
    end

endmodule
